// File: rtl/sub_16bits_serial_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM states,
// operation encodings, nibble width and the nibble counter sizing helper.
package sub_16bits_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int NIBBLE_W = 4;

  // Width of the nibble counter; a single-nibble operand still needs one bit
  // so the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int width);
    int n;
    n = width / NIBBLE_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_16bits_serial_cla_4bits_slice.sv
// One 4-bit carry-lookahead slice. Purely combinational; the top level
// time-multiplexes a single instance over all nibbles of the operands.
module cla_4bits_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] p;
  logic [3:0] g;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;

  // Propagate/generate terms and fully expanded lookahead carries.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s  = p ^ {c3, c2, c1, ci};
    co = c4;
  end

endmodule

// File: rtl/sub_16bits_serial.sv
// Nibble-serial adder/subtractor. Operands are captured on accept, then one
// nibble per clock is pushed through a shared 4-bit lookahead slice, least
// significant nibble first, with the carry held in a register between steps.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; neither
// depends combinationally on the partner's valid/ready, and the producer
// must hold its payload stable while valid is high and ready is low.
module sub_16bits_serial
  import sub_16bits_serial_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cbi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cbo,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             chain_c;
  logic             op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cbo_q;
  logic             ovf_q;

  logic             accept;
  logic             release_res;
  logic             last_nib;
  logic [3:0]       a_nib;
  logic [3:0]       b_raw;
  logic [3:0]       b_nib;
  logic [3:0]       s_nib;
  logic             co_nib;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_nxt;

  assign accept      = in_valid & in_ready;
  assign release_res = out_valid & out_ready;
  assign last_nib    = (state == CALC) && (cnt == LAST_CNT);

  // Select the current nibble; subtraction feeds the inverted b nibble so
  // a - b - cbi becomes a + ~b + ~cbi.
  always_comb begin
    a_nib = a_q[NIBBLE_W*cnt +: NIBBLE_W];
    b_raw = b_q[NIBBLE_W*cnt +: NIBBLE_W];
    b_nib = (op_q == OP_SUB) ? ~b_raw : b_raw;
  end

  cla_4bits_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (chain_c),
    .s  (s_nib),
    .co (co_nib)
  );

  // Signed overflow from operand sign bits and the sign of the final nibble.
  always_comb begin
    a_msb = a_q[WIDTH-1];
    b_msb = b_q[WIDTH-1];
    if (op_q == OP_SUB) begin
      ovf_nxt = (a_msb != b_msb) && (s_nib[3] != a_msb);
    end else begin
      ovf_nxt = (a_msb == b_msb) && (s_nib[3] != a_msb);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = CALC;
      CALC:    if (last_nib)    state_nxt = DONE;
      DONE:    if (release_res) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: handshake flags and the debug view of the state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  // Operand capture and per-nibble datapath update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      chain_c <= 1'b0;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cbo_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          op_q    <= op;
          a_q     <= a;
          b_q     <= b;
          cnt     <= '0;
          chain_c <= (op == OP_SUB) ? ~cbi : cbi;
        end
      end else if (state == CALC) begin
        res_q[NIBBLE_W*cnt +: NIBBLE_W] <= s_nib;
        chain_c <= co_nib;
        if (last_nib) begin
          cbo_q <= (op_q == OP_SUB) ? ~co_nib : co_nib;
          ovf_q <= ovf_nxt;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign res = res_q;
  assign cbo = cbo_q;
  assign ovf = ovf_q;

endmodule

// File: doc/sub_16bits_serial.md
SUB_16BITS_SERIAL -- requirements
Module: sub_16bits_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width; a multiple of 4, from 4 to 64.
REQ-002 SHALL have ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports:
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- op  input  1  0 = add (a+b+cbi); 1 = subtract (a-b-cbi).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- cbi  input  1  carry-in (add) or borrow-in (sub).
REQ-004 SHALL have ports:
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- res  output  WIDTH  sum or difference.
- cbo  output  1  carry-out (add) or borrow-out (sub).
- ovf  output  1  two's-complement signed overflow.

Function
REQ-005 SHALL implement an FSM with states IDLE, CALC and DONE, plus a nibble counter cnt of width clog2(WIDTH/4).
REQ-006 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-007 Accept: on an edge with in_valid&in_ready, SHALL latch op, a, b and cbi, set cnt=0, and move to CALC.
- a, b, op and cbi changes after acceptance SHALL be ignored.
REQ-008 Each CALC edge SHALL process nibble cnt using one 4-bit lookahead slice.
- Add: operands a[4cnt+3:4cnt] and b[4cnt+3:4cnt].
- Sub: operands a nibble and ~b nibble.
- The slice writes res[4cnt+3:4cnt] and a registered chain carry, then increments cnt.
REQ-009 Chain carry initial value SHALL be cbi for add and ~cbi for sub.
REQ-010 Final carry: cbo SHALL equal the final chain carry for add, or its inverse for sub (borrow=1 when a < b+cbi unsigned).
REQ-011 ovf SHALL be 1 exactly when the true signed result is outside the WIDTH-bit two's-complement range.
- Add: a[MSB]==b[MSB] and res[MSB]!=a[MSB].
- Sub: a[MSB]!=b[MSB] and res[MSB]!=a[MSB].
REQ-012 On the edge processing the last nibble, the FSM SHALL move to DONE, with cbo and ovf registered on that same edge.
- Latency: out_valid rises exactly WIDTH/4 edges after the accept edge (4 edges at WIDTH=16).
REQ-013 In DONE, res, cbo and ovf SHALL hold stable while out_ready=0 for any number of cycles.
REQ-014 On an edge with out_valid&out_ready, the FSM SHALL return to IDLE.
- in_ready rises the next cycle; there is no same-cycle accept in DONE.
- res, cbo and ovf SHALL retain their values until the next result overwrites them.
REQ-015 in_valid while not in IDLE SHALL have no effect; out_ready outside DONE SHALL have no effect.

Reset
REQ-016 rst_n low, asynchronously and at any time including mid-CALC or in DONE, SHALL force:
- state = IDLE, cnt = 0, chain carry = 0.
- res = 0, cbo = 0, ovf = 0, out_valid = 0, in_ready = 1.
- Any in-flight operation is discarded.
REQ-017 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-018 A shared package SHALL hold the FSM state enumeration (IDLE, CALC, DONE), the op encodings (OP_ADD=0, OP_SUB=1), and the nibble width constant 4.
REQ-019 The nibble datapath SHALL be one combinational sub-module, cla_4bits_slice, with these ports and equations:
- Ports: a[3:0], b[3:0], ci in; s[3:0], co out.
- Equations: p=a^b, g=a&b; lookahead carries c1..c4; s=p^{c3,c2,c1,ci}.
REQ-020 The top level SHALL instantiate exactly one cla_4bits_slice, time-multiplexed over the nibbles.

Verification (WIDTH=16)
REQ-021 sub a=0x0000 b=0x0001 cbi=0 -> res=0xFFFF cbo=1 ovf=0, out_valid exactly 4 edges after accept.
REQ-022 sub a=0x8000 b=0x0001 cbi=0 -> res=0x7FFF cbo=0 ovf=1; sub a=0x1234 b=0x1234 cbi=1 -> res=0xFFFF cbo=1 ovf=0.
REQ-023 add a=0xFFFF b=0x0001 cbi=0 -> res=0x0000 cbo=1 ovf=0; add a=0x7FFF b=0x0001 -> res=0x8000 cbo=0 ovf=1.
REQ-024 Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid=1, res/cbo/ovf stable, in_ready=0; operands toggled during CALC -> result unchanged.
REQ-025 Reset: rst_n pulsed low after the 2nd CALC edge -> all outputs 0 and in_ready=1 immediately, no out_valid; a new operation afterwards is correct.
REQ-026 Random: 10k back-to-back add/sub transactions with random out_ready -> res/cbo/ovf match a reference model; no lost or duplicated results.
